// File: rtl/add8_share_arbiter.sv
// Round-robin arbiter that time-shares a single external 8-bit adder core among NREQ
// requesters. The core sits between a registered operand stage and a registered response stage.
module add8_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  input  logic [8:0]          add_o,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [8:0]          rsp_sum,
  output logic [CNT_W-1:0]    op_count,
  output logic                busy
);

  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  logic [ID_W-1:0] ptr;
  logic            adv1, adv2;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic [7:0]      sel_a, sel_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign adv2 = !rsp_valid || rsp_ready;
  assign adv1 = !vld_p1 || adv2;
  assign busy = vld_p1 || rsp_valid;

  // First asserted requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NREQ))
        scan_sum = scan_sum - (ID_W+1)'(NREQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && adv1 && grant_vld)
      req_ready[grant_idx] = 1'b1;
  end

  assign sel_a = req_a[{grant_idx, 3'b000} +: 8];
  assign sel_b = req_b[{grant_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      ptr       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      op_count  <= '0;
    end else begin
      // S1: operand register feeding the adder core
      if (adv1) begin
        if (grant_vld) begin
          add_a  <= sel_a;
          add_b  <= sel_b;
          id_p1  <= grant_idx;
          vld_p1 <= 1'b1;
          if ({1'b0, grant_idx} == (ID_W+1)'(NREQ-1))
            ptr <= '0;
          else
            ptr <= grant_idx + ID_W'(1);
        end else begin
          vld_p1 <= 1'b0;
        end
      end
      // S2: response register capturing the core sum
      if (adv2) begin
        if (vld_p1) begin
          rsp_valid <= 1'b1;
          rsp_sum   <= add_o;
          rsp_id    <= id_p1;
        end else begin
          rsp_valid <= 1'b0;
        end
      end
      if (rsp_valid && rsp_ready)
        op_count <= sat_inc(op_count);
    end
  end

endmodule
